// File: rtl/alu_mdu_unit.sv
// rtl/alu_mdu_unit.sv - execute-stage ALU/shifter with iterative shift-add multiplier and HI/LO
module alu_mdu_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [1:0]         ALUop,
  input  logic [5:0]         funct,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic [WIDTH-1:0]   Output,
  output logic               Zero,
  output logic               busy,
  output logic               stall
);

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_SUB    = 2'b01;
  localparam logic [1:0] OP_FUNCT  = 2'b10;
  localparam logic [1:0] OP_OR     = 2'b11;

  localparam logic [SHAMT_W-1:0] LAST_COUNT = SHAMT_W'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             state;
  logic [SHAMT_W-1:0] count;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  logic               is_mdu_op;
  logic               start_mul;
  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] acc_next;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic               sub_ovf;
  logic               slt_bit;
  logic [WIDTH-1:0]   alu_result;

  // Hazard detection: MULTU/MFHI/MFLO must wait while the multiplier owns HI/LO
  always_comb begin
    is_mdu_op = (ALUop == OP_FUNCT) &&
                ((funct == F_MULTU) || (funct == F_MFHI) || (funct == F_MFLO));
    stall     = valid_in && busy && is_mdu_op;
    start_mul = valid_in && !busy && (ALUop == OP_FUNCT) && (funct == F_MULTU);
  end

  // One shift-add step: low half of acc holds the not-yet-consumed multiplier bits
  always_comb begin
    partial  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_next = {partial, acc[WIDTH-1:1]};
  end

  // Multiplier FSM: IDLE -> RUN for WIDTH cycles -> IDLE, committing HI/LO on the last step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      count <= '0;
      mcand <= '0;
      acc   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_mul) begin
            mcand <= dataA;
            acc   <= {{WIDTH{1'b0}}, dataB};
            count <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          count <= count + SHAMT_W'(1);
          if (count == LAST_COUNT) begin
            hi    <= acc_next[2*WIDTH-1:WIDTH];
            lo    <= acc_next[WIDTH-1:0];
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Adder/subtractor and overflow-corrected signed less-than
  always_comb begin
    sum     = dataA + dataB;
    diff    = dataA - dataB;
    sub_ovf = (dataA[WIDTH-1] != dataB[WIDTH-1]) && (diff[WIDTH-1] != dataA[WIDTH-1]);
    slt_bit = diff[WIDTH-1] ^ sub_ovf;
  end

  // Result select from ALUop and funct; unknown funct and MULTU give zero
  always_comb begin
    alu_result = '0;
    case (ALUop)
      OP_ADD: alu_result = sum;
      OP_SUB: alu_result = diff;
      OP_OR:  alu_result = dataA | dataB;
      default: begin
        case (funct)
          F_AND:   alu_result = dataA & dataB;
          F_OR:    alu_result = dataA | dataB;
          F_ADD:   alu_result = sum;
          F_SUB:   alu_result = diff;
          F_SLT:   alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
          F_SLL:   alu_result = dataA << dataB[SHAMT_W-1:0];
          F_SRL:   alu_result = dataA >> dataB[SHAMT_W-1:0];
          F_MFHI:  alu_result = hi;
          F_MFLO:  alu_result = lo;
          default: alu_result = '0;
        endcase
      end
    endcase
  end

  // A stalled instruction must not leak a result or a Zero flag downstream
  always_comb begin
    Output = stall ? '0 : alu_result;
    Zero   = !stall && (alu_result == '0);
  end

endmodule

// File: tb/tb_alu_mdu_unit.sv
// tb/tb_alu_mdu_unit.sv - directed-vector bench for alu_mdu_unit at WIDTH 32 and 8
module tb_alu_mdu_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        v32 = 1'b0;
  logic [1:0]  op32 = 2'b00;
  logic [5:0]  f32 = 6'd0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic [31:0] out32;
  logic        z32, busy32, stall32;

  logic        v8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [5:0]  f8 = 6'd0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [7:0]  out8;
  logic        z8, busy8, stall8;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] FN = 2'b10;

  alu_mdu_unit #(.WIDTH(32), .SHAMT_W(5)) dut32 (
    .clk(clk), .rst(rst), .valid_in(v32), .ALUop(op32), .funct(f32),
    .dataA(a32), .dataB(b32), .Output(out32), .Zero(z32), .busy(busy32), .stall(stall32)
  );

  alu_mdu_unit #(.WIDTH(8), .SHAMT_W(3)) dut8 (
    .clk(clk), .rst(rst), .valid_in(v8), .ALUop(op8), .funct(f8),
    .dataA(a8), .dataB(b8), .Output(out8), .Zero(z8), .busy(busy8), .stall(stall8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive32(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
    v32 = v; op32 = op; f32 = f; a32 = a; b32 = b;
    #1;
  endtask

  task automatic drive8(input logic v, input logic [1:0] op, input logic [5:0] f,
                        input logic [7:0] a, input logic [7:0] b);
    v8 = v; op8 = op; f8 = f; a8 = a; b8 = b;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    int scnt;
    int bad;
    int guard;

    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("reset_busy", 64'(busy32), 64'd0);
    check("reset_stall", 64'(stall32), 64'd0);
    drive32(1, FN, 6'd16, 32'h0, 32'h0);
    check("reset_hi", 64'(out32), 64'd0);
    drive32(1, FN, 6'd18, 32'h0, 32'h0);
    check("reset_lo", 64'(out32), 64'd0);

    // Combinational ALU and shifter vectors
    drive32(1, FN, 6'd36, 32'h0000F0F0, 32'h0000FF00);
    check("and", 64'(out32), 64'h0000F000);
    drive32(1, 2'b11, 6'd0, 32'h0000F0F0, 32'h0000FF00);
    check("or_aluop", 64'(out32), 64'h0000FFF0);
    drive32(1, FN, 6'd42, 32'h80000000, 32'h00000001);
    check("slt_neg_pos", 64'(out32), 64'd1);
    drive32(1, FN, 6'd42, 32'h7FFFFFFF, 32'hFFFFFFFF);
    check("slt_ovf", 64'(out32), 64'd0);
    drive32(1, 2'b01, 6'd0, 32'd5, 32'd5);
    check("sub_out", 64'(out32), 64'd0);
    check("sub_zero", 64'(z32), 64'd1);
    drive32(1, 2'b00, 6'd0, 32'h7FFFFFFF, 32'd1);
    check("add_wrap", 64'(out32), 64'h80000000);
    check("add_zero", 64'(z32), 64'd0);
    drive32(0, FN, 6'd0, 32'h00000001, 32'h00000023);
    check("sll", 64'(out32), 64'h00000008);
    drive32(1, FN, 6'd2, 32'h80000000, 32'd31);
    check("srl", 64'(out32), 64'h00000001);
    drive32(1, FN, 6'h3F, 32'h12345678, 32'h9ABCDEF0);
    check("unknown_funct", 64'(out32), 64'd0);

    // MULTU all-ones, with an ADD passing through while busy
    tick();
    drive32(1, FN, 6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick(); #1;
    drive32(1, 2'b00, 6'd25, 32'd3, 32'd4);
    check("add_busy_out", 64'(out32), 64'd7);
    check("add_busy_stall", 64'(stall32), 64'd0);
    drive32(0, 2'b00, 6'd0, 32'd0, 32'd0);
    cnt = 0; guard = 0;
    while (busy32 && guard < 100) begin
      cnt++; guard++;
      tick(); #1;
    end
    check("mul32_busy_cycles", 64'(cnt), 64'd32);
    drive32(1, FN, 6'd16, 32'h0, 32'h0);
    check("mul32_hi", 64'(out32), 64'hFFFFFFFE);
    drive32(1, FN, 6'd18, 32'h0, 32'h0);
    check("mul32_lo", 64'(out32), 64'h00000001);

    // MFHI three cycles after MULTU must stall until the product lands
    tick();
    drive32(1, FN, 6'd25, 32'h00010000, 32'h00010000);
    tick(); #1;
    drive32(0, 2'b00, 6'd0, 32'h0, 32'h0);
    tick(); tick(); #1;
    drive32(1, FN, 6'd16, 32'h0, 32'h0);
    check("mfhi_stall_first", 64'(stall32), 64'd1);
    scnt = 0; bad = 0; guard = 0;
    while (busy32 && guard < 100) begin
      if (stall32) scnt++;
      if (out32 != 32'h0 || z32 != 1'b0) bad++;
      guard++;
      tick(); #1;
    end
    check("mfhi_stall_cycles", 64'(scnt), 64'd30);
    check("mfhi_stalled_outputs", 64'(bad), 64'd0);
    check("mfhi_after_stall", 64'(stall32), 64'd0);
    check("mfhi_result", 64'(out32), 64'h00000001);
    drive32(1, FN, 6'd18, 32'h0, 32'h0);
    check("mflo_result", 64'(out32), 64'h00000000);

    // Reset during the fifth busy cycle discards the multiply and clears HI/LO
    tick();
    drive32(1, FN, 6'd25, 32'd7, 32'd9);
    tick(); #1;
    drive32(0, 2'b00, 6'd0, 32'h0, 32'h0);
    repeat (4) tick();
    #1;
    drive32(1, FN, 6'd18, 32'h0, 32'h0);
    check("rst_mid_busy_before", 64'(busy32), 64'd1);
    check("rst_mid_stall_before", 64'(stall32), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy32), 64'd0);
    check("rst_mid_stall", 64'(stall32), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_lo", 64'(out32), 64'd0);
    drive32(1, FN, 6'd16, 32'h0, 32'h0);
    check("rst_mid_hi", 64'(out32), 64'd0);
    drive32(0, 2'b00, 6'd0, 32'h0, 32'h0);

    // WIDTH 8: back-to-back MULTU stalls for the whole first multiply
    tick();
    drive8(1, FN, 6'd25, 8'hFF, 8'hFF);
    tick(); #1;
    cnt = 0; scnt = 0; guard = 0;
    while (busy8 && guard < 100) begin
      cnt++;
      if (stall8) scnt++;
      guard++;
      tick(); #1;
    end
    check("mul8_busy_cycles", 64'(cnt), 64'd8);
    check("mul8_b2b_stall_cycles", 64'(scnt), 64'd8);
    check("mul8_b2b_stall_clear", 64'(stall8), 64'd0);
    tick(); #1;
    check("mul8_second_accepted", 64'(busy8), 64'd1);
    drive8(0, 2'b00, 6'd0, 8'h0, 8'h0);
    cnt = 0; guard = 0;
    while (busy8 && guard < 100) begin
      cnt++; guard++;
      tick(); #1;
    end
    check("mul8_second_busy", 64'(cnt), 64'd8);
    drive8(1, FN, 6'd16, 8'h0, 8'h0);
    check("mul8_hi", 64'(out8), 64'hFE);
    drive8(1, FN, 6'd18, 8'h0, 8'h0);
    check("mul8_lo", 64'(out8), 64'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
